micro_ucr_hash_minero: RTL and testbench

Proof-of-work responder for the micro_ucr_hash stage: it takes the 12-byte data block and the 8-bit target driven by the stimulus/probador side and searches 28-bit nonces. For each nonce it computes the 24-bit micro_ucr_hash over the 16-byte message, one round per cycle. It then returns the winning message on `bounty` with `terminado` high. It is the device-under-test end of the `clk`/`inicio`/`bloque_datos`/`target` → `bounty`/`terminado` interface.

---
 rtl/micro_ucr_hash_pkg.sv | 37 +++
 rtl/micro_ucr_hash_minero_if.sv | 30 +++
 rtl/micro_ucr_hash_ronda.sv | 35 +++
 rtl/micro_ucr_hash_minero.sv | 119 +++++++++++
 tb/tb_micro_ucr_hash_minero.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_ucr_hash_pkg.sv
// micro_ucr_hash_pkg: hash constants, round geometry and search FSM states
// shared by the micro_ucr_hash miner and its round datapath.
package micro_ucr_hash_pkg;

    localparam logic [7:0] H0_INIT = 8'h01;
    localparam logic [7:0] H1_INIT = 8'h89;
    localparam logic [7:0] H2_INIT = 8'hFE;
    localparam logic [23:0] H_INIT = {H0_INIT, H1_INIT, H2_INIT};

    localparam logic [7:0] K0 = 8'h99;
    localparam logic [7:0] K1 = 8'hA1;

    localparam int ROUNDS    = 32;
    localparam int SPLIT     = 16;
    localparam int MSG_BYTES = 16;

    localparam logic [4:0] SPLIT_IDX  = 5'(SPLIT);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_CHECK,
        ST_DONE,
        ST_EXHAUSTED
    } state_t;

    function automatic logic [7:0] rotl4(input logic [7:0] v);
        return {v[3:0], v[7:4]};
    endfunction

    function automatic logic [7:0] rotl2(input logic [7:0] v);
        return {v[5:0], v[7:6]};
    endfunction

endpackage

// File: rtl/micro_ucr_hash_minero_if.sv
// micro_ucr_hash_minero_if: probador <-> miner bundle.
// master drives block/target/inicio, slave returns the result.
interface micro_ucr_hash_minero_if;

    logic         inicio;
    logic [95:0]  bloque_datos;
    logic [7:0]   target;
    logic [123:0] bounty;
    logic         terminado;
    logic         valido;

    modport master (
        output inicio,
        output bloque_datos,
        output target,
        input  bounty,
        input  terminado,
        input  valido
    );

    modport slave (
        input  inicio,
        input  bloque_datos,
        input  target,
        output bounty,
        output terminado,
        output valido
    );

endinterface

// File: rtl/micro_ucr_hash_ronda.sv
// micro_ucr_hash_ronda: one combinational compression round.
// H is packed {H0, H1, H2}; idx selects the early/late round constants.
module micro_ucr_hash_ronda
    import micro_ucr_hash_pkg::*;
(
    input  logic [23:0] h_i,
    input  logic [7:0]  w_i,
    input  logic [4:0]  idx_i,
    output logic [23:0] h_o
);

    logic [7:0] h0;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] k;
    logic [7:0] x;
    logic [7:0] a;

    // Mix the message byte into H0, shift the old state down one slot.
    always_comb begin
        h0 = h_i[23:16];
        h1 = h_i[15:8];
        h2 = h_i[7:0];
        if (idx_i <= SPLIT_IDX) begin
            k = K0;
            x = h1 ^ h2;
        end else begin
            k = K1;
            x = h0 ^ h2;
        end
        a   = rotl4(h2) + x + k + w_i;
        h_o = {a, rotl2(h0), h1};
    end

endmodule

// File: rtl/micro_ucr_hash_minero.sv
// micro_ucr_hash_minero: sequential nonce search, 34 cycles per nonce.
// Build option MINERO_RESUME_EN: after a found result the next search resumes at nonce+1.
module micro_ucr_hash_minero
    import micro_ucr_hash_pkg::*;
#(
    parameter int NONCE_W = 28
) (
    input logic                    clk,
    input logic                    reset,
    micro_ucr_hash_minero_if.slave bus
);

    localparam logic [NONCE_W-1:0] NONCE_INC = {{(NONCE_W - 1){1'b0}}, 1'b1};

    state_t                     state_q;
    logic [NONCE_W-1:0]         nonce_q;
    logic [4:0]                 rcnt_q;
    logic [MSG_BYTES-1:0][7:0]  win_q;
    logic [23:0]                h_q;
    logic [123:0]               bounty_q;
    logic                       terminado_q;
    logic                       valido_q;

    logic [23:0]                h_d;
    logic [7:0]                 w_new_d;
    logic [8*MSG_BYTES-1:0]     msg_d;
    logic                       hit_d;
    logic                       last_d;

    assign w_new_d = win_q[13] | (win_q[7] ^ win_q[2]);
    assign msg_d   = {bus.bloque_datos, 32'(nonce_q)};
    assign hit_d   = (h_q[23:16] < bus.target) && (h_q[15:8] < bus.target);
    assign last_d  = &nonce_q;

    assign bus.bounty    = bounty_q;
    assign bus.terminado = terminado_q;
    assign bus.valido    = valido_q;

    micro_ucr_hash_ronda u_ronda (
        .h_i   (h_q),
        .w_i   (win_q[0]),
        .idx_i (rcnt_q),
        .h_o   (h_d)
    );

    // Search FSM: load, 32 rounds, check, then next nonce or a held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            nonce_q     <= '0;
            rcnt_q      <= '0;
            win_q       <= '0;
            h_q         <= '0;
            bounty_q    <= '0;
            terminado_q <= 1'b0;
            valido_q    <= 1'b0;
        end else if (!bus.inicio && (state_q != ST_IDLE)) begin
            state_q     <= ST_IDLE;
            bounty_q    <= '0;
            terminado_q <= 1'b0;
            valido_q    <= 1'b0;
`ifdef MINERO_RESUME_EN
            if (state_q == ST_DONE) begin
                nonce_q <= nonce_q + NONCE_INC;
            end else begin
                nonce_q <= '0;
            end
`else
            nonce_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.inicio) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int j = 0; j < MSG_BYTES; j++) begin
                        win_q[j] <= msg_d[8*(MSG_BYTES-1-j) +: 8];
                    end
                    h_q     <= H_INIT;
                    rcnt_q  <= '0;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    h_q    <= h_d;
                    win_q  <= {w_new_d, win_q[MSG_BYTES-1:1]};
                    rcnt_q <= rcnt_q + 5'd1;
                    if (rcnt_q == LAST_ROUND) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit_d) begin
                        bounty_q    <= {bus.bloque_datos, 28'(nonce_q)};
                        terminado_q <= 1'b1;
                        valido_q    <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (last_d) begin
                        terminado_q <= 1'b1;
                        valido_q    <= 1'b0;
                        state_q     <= ST_EXHAUSTED;
                    end else begin
                        nonce_q <= nonce_q + NONCE_INC;
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE, ST_EXHAUSTED: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_ucr_hash_minero.sv
// tb_micro_ucr_hash_minero: directed bench for the micro_ucr_hash miner.
// A 28-bit instance covers found/abort/release, a 4-bit one covers exhaustion.
module tb_micro_ucr_hash_minero;
    import micro_ucr_hash_pkg::*;

    localparam logic [95:0] BLK = 96'h397d9f2f40ca9e6c6b1f3324;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_found = 0;
    logic [123:0] found_bounty;

    micro_ucr_hash_minero_if bif ();
    micro_ucr_hash_minero_if bif4 ();

    micro_ucr_hash_minero #(.NONCE_W(28)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    micro_ucr_hash_minero #(.NONCE_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif4)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_hash(input logic [95:0] blk,
                                               input logic [27:0] nonce,
                                               input int nr);
        logic [7:0] w [0:31];
        logic [127:0] msg;
        logic [7:0] h0, h1, h2, k, x, a;
        msg = {blk, 4'h0, nonce};
        for (int i = 0; i < 16; i++) w[i] = msg[127-8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        h0 = 8'h01;
        h1 = 8'h89;
        h2 = 8'hFE;
        for (int i = 0; i < nr; i++) begin
            if (i <= 16) begin
                k = 8'h99;
                x = h1 ^ h2;
            end else begin
                k = 8'hA1;
                x = h0 ^ h2;
            end
            a  = {h2[3:0], h2[7:4]} + x + k + w[i];
            h2 = h1;
            h1 = {h0[5:0], h0[7:6]};
            h0 = a;
        end
        return {h0, h1, h2};
    endfunction

    function automatic int model_first(input logic [95:0] blk,
                                       input logic [7:0] tgt,
                                       input int start);
        logic [23:0] h;
        for (int n = start; n < (1 << 28); n++) begin
            h = model_hash(blk, 28'(n), 32);
            if ((h[23:16] < tgt) && (h[15:8] < tgt)) return n;
        end
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at e0+#1: result must appear exactly t_edges edges later.
    task automatic run_to_hit(input int t_edges, input logic [123:0] exp_b,
                              input logic [7:0] tgt, input string tag);
        logic [23:0] h;
        step(t_edges - 1);
        checks++;
        if (bif.terminado !== 1'b0) begin
            errors++;
            $display("FAIL %s early_terminado: got %b want 0", tag, bif.terminado);
        end
        step(1);
        checks++;
        if (bif.terminado !== 1'b1) begin
            errors++;
            $display("FAIL %s terminado: got %b want 1", tag, bif.terminado);
        end
        checks++;
        if (bif.valido !== 1'b1) begin
            errors++;
            $display("FAIL %s valido: got %b want 1", tag, bif.valido);
        end
        checks++;
        if (bif.bounty !== exp_b) begin
            errors++;
            $display("FAIL %s bounty: got %h want %h", tag, bif.bounty, exp_b);
        end
        h = model_hash(bif.bounty[123:28], bif.bounty[27:0], 32);
        checks++;
        if (!((h[23:16] < tgt) && (h[15:8] < tgt))) begin
            errors++;
            $display("FAIL %s bounty_hash: got H=%h want H0,H1 < %h", tag, h, tgt);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bif.inicio = 1'b0;
        bif.bloque_datos = BLK;
        bif.target = 8'h0a;
        bif4.inicio = 1'b0;
        bif4.bloque_datos = BLK;
        bif4.target = 8'h00;
        step(3);
        checks++;
        if (bif.terminado !== 1'b0) begin
            errors++;
            $display("FAIL rst_terminado: got %b want 0", bif.terminado);
        end
        checks++;
        if (bif.valido !== 1'b0) begin
            errors++;
            $display("FAIL rst_valido: got %b want 0", bif.valido);
        end
        checks++;
        if (bif.bounty !== 124'd0) begin
            errors++;
            $display("FAIL rst_bounty: got %h want 0", bif.bounty);
        end
        checks++;
        if (bif4.terminado !== 1'b0) begin
            errors++;
            $display("FAIL rst4_terminado: got %b want 0", bif4.terminado);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_round_found;
        int t_found;
        n_found = model_first(BLK, 8'h0a, 0);
        found_bounty = {BLK, 28'(n_found)};
        t_found = 1 + 34 * (n_found + 1);
        $display("info: model first hit nonce %0d", n_found);
        bif.target = 8'h0a;
        bif.inicio = 1'b1;
        step(12);
        checks++;
        if (dut.state_q !== ST_ROUND) begin
            errors++;
            $display("FAIL mid_state: got %0d want %0d", dut.state_q, ST_ROUND);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        checks++;
        if (bif.terminado !== 1'b0 || bif.valido !== 1'b0 || bif.bounty !== 124'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b/%b/%h want 0/0/0",
                     bif.terminado, bif.valido, bif.bounty);
        end
        reset = 1'b0;
        run_to_hit(t_found, found_bounty, 8'h0a, "found");
    endtask

    task automatic test_release;
        int s;
        int m;
        bif.inicio = 1'b0;
        step(1);
        checks++;
        if (bif.terminado !== 1'b0 || bif.valido !== 1'b0 || bif.bounty !== 124'd0) begin
            errors++;
            $display("FAIL release_outputs: got %b/%b/%h want 0/0/0",
                     bif.terminado, bif.valido, bif.bounty);
        end
`ifdef MINERO_RESUME_EN
        s = n_found + 1;
`else
        s = 0;
`endif
        m = model_first(BLK, 8'hFF, s);
        bif.target = 8'hFF;
        bif.inicio = 1'b1;
        run_to_hit(1 + 34 * (m - s + 1), {BLK, 28'(m)}, 8'hFF, "release");
        bif.inicio = 1'b0;
        step(1);
        checks++;
        if (bif.terminado !== 1'b0) begin
            errors++;
            $display("FAIL release2_terminado: got %b want 0", bif.terminado);
        end
    endtask

    task automatic test_abort;
        int abort_cyc;
        logic seen;
        abort_cyc = (n_found >= 2) ? 100 : 20;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bif.target = 8'h0a;
        bif.inicio = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < abort_cyc; i++) begin
            step(1);
            if (bif.terminado !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_early_terminado: got 1 want 0");
        end
        bif.inicio = 1'b0;
        step(1);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        checks++;
        if (bif.terminado !== 1'b0) begin
            errors++;
            $display("FAIL abort_terminado: got %b want 0", bif.terminado);
        end
        bif.inicio = 1'b1;
        run_to_hit(1 + 34 * (n_found + 1), found_bounty, 8'h0a, "abort_rerun");
        bif.inicio = 1'b0;
        step(1);
    endtask

    task automatic test_exhaust_rounds;
        int p;
        int n;
        logic [23:0] exp_h;
        logic seen;
        seen = 1'b0;
        bif4.target = 8'h00;
        bif4.inicio = 1'b1;
        for (int t = 1; t <= 545; t++) begin
            step(1);
            p = (t - 1) % 34;
            n = (t - 1) / 34;
            if (n < 4 && p >= 1) begin
                exp_h = model_hash(BLK, 28'(n), p - 1);
                checks++;
                if (dut4.h_q !== exp_h) begin
                    errors++;
                    $display("FAIL round_h n=%0d r=%0d: got %h want %h",
                             n, p - 1, dut4.h_q, exp_h);
                end
            end
            if (t < 545 && bif4.terminado !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_early_terminado: got 1 want 0");
        end
        checks++;
        if (bif4.terminado !== 1'b1 || bif4.valido !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_flags: got %b/%b want 1/0", bif4.terminado, bif4.valido);
        end
        checks++;
        if (bif4.bounty !== 124'd0) begin
            errors++;
            $display("FAIL exhaust_bounty: got %h want 0", bif4.bounty);
        end
        step(5);
        checks++;
        if (bif4.terminado !== 1'b1 || bif4.valido !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_hold: got %b/%b want 1/0", bif4.terminado, bif4.valido);
        end
        bif4.inicio = 1'b0;
        step(1);
        checks++;
        if (bif4.terminado !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_release: got %b want 0", bif4.terminado);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_round_found();
        test_release();
        test_abort();
        test_exhaust_rounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
